spi_slave_axis: RTL and testbench
=================================

Name: spi_slave_axis

Overview:
- SPI slave (mode 0, MSB first) that turns each chip-select frame from the host SoC into one byte-wide AXI stream packet; tlast marks the last byte before cs_n rises.
- Its output_axis feeds the input_axis of soc_interface_wb_8 directly.
- Its input_axis takes soc_interface_wb_8 output_axis response bytes and shifts them out on MISO.
- All SPI pins are oversampled in the clk domain; no SPI clock domain exists.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on sclk, cs_n and mosi before edge detection (minimum 2).
- IDLE_BYTE, 8'hFF, byte shifted out on MISO when no response byte is available.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- sclk  in  1  SPI clock, async; f_sclk ≤ f_clk/8
- cs_n  in  1  SPI chip select, active-low, async
- mosi  in  1  SPI data in
- miso  out  1  SPI data out
- miso_t  out  1  MISO tristate enable, 1 = high-Z
- input_axis_tdata  in  8  response byte
- input_axis_tvalid  in  1  response valid
- input_axis_tready  out  1  response accepted (single-cycle pulse)
- output_axis_tdata  out  8  received byte
- output_axis_tvalid  out  1  received byte valid
- output_axis_tready  in  1  downstream ready
- output_axis_tlast  out  1  last byte of frame
- output_axis_tuser  out  1  frame corrupted by overrun, valid with tlast
- busy  out  1  cs_n (synchronized) low, or a byte still held in the pending or output register
- overrun  out  1  one-cycle pulse when a received byte is dropped

Behaviour:
- Reset state:
  - All outputs 0, except miso=1 and miso_t=1.
  - Synchronizers reset to sclk=0, cs_n=1, mosi=0.
  - Bit counter 0; pending and output registers empty.
- Edge detection:
  - Edges are detected on the last synchronizer stage against one extra delay flop.
  - sclk rise samples mosi; sclk fall shifts miso.
- Bit counter:
  - 3 bits; byte completes on the 8th sclk rise, then wraps to 0.
  - cs_n fall or cs_n rise clears the counter.
  - A partial byte at cs_n rise is discarded silently.
- Two-stage output:
  - Pending register P: data, last, user, valid. Output register O drives output_axis.
  - O loads from P when O is empty, or when O is being accepted (tvalid & tready) that cycle.
  - O holds tdata, tlast and tuser stable while tvalid=1.
- Byte complete:
  - P empty: the new byte enters P with last=0.
  - P valid and P can move to O this cycle: P moves to O; the new byte enters P.
  - Otherwise: the new byte is dropped, overrun pulses, P.user is set, and the rest of the frame is dropped until cs_n rises.
- cs_n rise with P valid: P.last=1; P moves to O as soon as allowed.
  - A P with last=1 never waits for a further byte.
- cs_n rise with P empty: nothing is emitted.
  - A frame with zero complete bytes produces no packet.
- Latency:
  - Byte n reaches output_axis 1 cycle after byte n+1 completes, or 1 cycle after cs_n rise is detected.
  - Both assume O is free.
- Simultaneous events:
  - Byte completion and cs_n rise in the same cycle cannot occur; cs_n edge handling takes priority.
  - O accept and P→O move in the same cycle are allowed (full throughput).
- MISO shift register:
  - Loaded at cs_n fall and at each byte completion.
  - Load source is input_axis_tdata, with tready pulsed for 1 cycle, if tvalid; otherwise IDLE_BYTE.
  - miso = shift[7]; each sclk fall shifts left.
  - miso_t = synchronized cs_n.
  - input_axis tlast does not exist; responses are byte-granular.
- cs_n rise mid-response: the shift register is discarded; the consumed byte is lost.
- rst asserted mid-frame: immediate return to the reset state.
  - A frame in progress at reset release is ignored until the next cs_n fall.

Optional Feature:
- SPI_SLAVE_AXIS_MISO_EN
  - Defined: MISO response path as described above.
  - Undefined: no shift register; miso=1, miso_t=1 constantly, input_axis_tready=0; the receive path is unchanged.

Decomposition:
- Shared package / include:
  - SPI mode constant (mode 0).
  - Default IDLE_BYTE.
  - Default SYNC_STAGES.
- One sub-module: spi_sync_bit, an N-stage synchronizer with async reset value parameter; instantiated three times.

Test Plan:
- Frame of bytes 0x11,0x22,0x33, tready=1 → output 0x11,0x22,0x33; tlast only on 0x33; tuser=0; no overrun.
- input_axis offers 0xA5,0x5A; 3-byte frame → MISO bytes 0xA5,0x5A,0xFF; two tready pulses.
- tready=0 for a 4-byte frame → 0x01 held in O, 0x02 in P; bytes 3 and 4 dropped; two overrun pulses. After release: 0x01 (tlast=0), then 0x02 (tlast=1, tuser=1).
- cs_n rises after 5 bits of byte 2 → one-byte packet, tlast=1; partial byte discarded; next frame aligns correctly.
- rst asserted mid-byte → miso_t=1 and outputs zero immediately; next clean frame 0xC3 → single byte 0xC3, tlast=1.
- Back-to-back frames separated by 2 clk of cs_n high, with continuous tready → two packets, no overrun, tlast on each final byte.

Source files
------------

// File: rtl/spi_slave_axis_pkg.sv
// Shared constants and types for the SPI slave to AXI-stream bridge.
`timescale 1ns/1ps
package spi_slave_axis_pkg;

    // SPI mode 0: CPOL=0 (sclk idles low), CPHA=0 (sample on rise).
    localparam int         SPI_MODE        = 0;
    localparam logic       SCLK_IDLE       = (SPI_MODE >= 2) ? 1'b1 : 1'b0;

    localparam logic [7:0] IDLE_BYTE_DEF   = 8'hFF;
    localparam int         SYNC_STAGES_DEF = 2;

    // WAIT: after reset, ignore any frame already in progress.
    typedef enum logic [1:0] {
        ST_WAIT,
        ST_IDLE,
        ST_RX,
        ST_DROP
    } rx_state_e;

    // One byte slot of the receive path (pending or output register).
    typedef struct packed {
        logic       valid;
        logic [7:0] data;
        logic       last;
        logic       user;
    } axis_byte_t;

endpackage

// File: rtl/spi_sync_bit.sv
// N-stage single-bit synchronizer with a configurable reset value.
`timescale 1ns/1ps
module spi_sync_bit #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) sync_q <= {STAGES{RST_VAL}};
        else       sync_q <= {sync_q[STAGES-2:0], d_i};
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave_axis.sv
// SPI mode-0 slave, oversampled in the clk domain. Each chip-select frame
// becomes one byte-wide AXI-stream packet; response bytes are shifted out
// on MISO when SPI_SLAVE_AXIS_MISO_EN is defined (otherwise MISO is idle).
`timescale 1ns/1ps
module spi_slave_axis
    import spi_slave_axis_pkg::*;
#(
    parameter int         SYNC_STAGES = SYNC_STAGES_DEF,
    parameter logic [7:0] IDLE_BYTE   = IDLE_BYTE_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_t,
    input  logic [7:0] input_axis_tdata,
    input  logic       input_axis_tvalid,
    output logic       input_axis_tready,
    output logic [7:0] output_axis_tdata,
    output logic       output_axis_tvalid,
    input  logic       output_axis_tready,
    output logic       output_axis_tlast,
    output logic       output_axis_tuser,
    output logic       busy,
    output logic       overrun
);

    // Cycles until the synchronizers reflect the pins after reset.
    localparam int FLUSH_CYC = SYNC_STAGES + 1;
    localparam int FW        = $clog2(FLUSH_CYC + 1);

    logic sclk_s, cs_s, mosi_s;
    logic sclk_d_q, cs_d_q;

    spi_sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(SCLK_IDLE)) u_sync_sclk (
        .clk_i(clk), .rst_i(rst), .d_i(sclk), .q_o(sclk_s));
    spi_sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk_i(clk), .rst_i(rst), .d_i(cs_n), .q_o(cs_s));
    spi_sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk_i(clk), .rst_i(rst), .d_i(mosi), .q_o(mosi_s));

    // Extra delay flops for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_d_q <= SCLK_IDLE;
            cs_d_q   <= 1'b1;
        end else begin
            sclk_d_q <= sclk_s;
            cs_d_q   <= cs_s;
        end
    end

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    assign sclk_rise = sclk_s & ~sclk_d_q;
    assign sclk_fall = ~sclk_s & sclk_d_q;
    assign cs_rise   = cs_s & ~cs_d_q;
    assign cs_fall   = ~cs_s & cs_d_q;

    rx_state_e     state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    rx_sr_q, rx_sr_d;
    logic [FW-1:0] flush_q, flush_d;
    axis_byte_t    p_q, p_d, o_q, o_d;
    logic          overrun_q;

    logic in_frame, flush_done, cs_fall_evt, cs_rise_evt, bit_evt, byte_done;
    logic o_free, p_last_eff, take_new, move, drop;
    logic [7:0] rx_byte;

    assign in_frame    = (state_q == ST_RX) || (state_q == ST_DROP);
    assign flush_done  = (flush_q == FW'(FLUSH_CYC));
    assign cs_fall_evt = cs_fall && (state_q == ST_IDLE);
    assign cs_rise_evt = cs_rise && in_frame;
    // cs_n edges win over a coincident sclk edge.
    assign bit_evt     = sclk_rise && in_frame && !cs_rise;
    assign byte_done   = bit_evt && (bit_cnt_q == 3'd7);
    assign rx_byte     = {rx_sr_q[6:0], mosi_s};

    // P only advances once its successor arrives or the frame has ended,
    // so tlast is known when the byte lands in O.
    assign o_free      = !o_q.valid || output_axis_tready;
    assign p_last_eff  = p_q.last || cs_rise_evt;
    assign take_new    = byte_done && (state_q == ST_RX) && (!p_q.valid || o_free);
    assign move        = p_q.valid && o_free && (p_last_eff || take_new);
    assign drop        = byte_done && !take_new;

    // Frame state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_WAIT;
        else     state_q <= state_d;
    end

    // Frame tracking: wait out a frame caught by reset, then RX until cs_n
    // rises, sticking in DROP after the first overrun.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT: if (flush_done && cs_s) state_d = ST_IDLE;
            ST_IDLE: if (cs_fall)            state_d = ST_RX;
            ST_RX: begin
                if (cs_rise)   state_d = ST_IDLE;
                else if (drop) state_d = ST_DROP;
            end
            ST_DROP: if (cs_rise)            state_d = ST_IDLE;
            default:                         state_d = ST_WAIT;
        endcase
    end

    // Bit counter, receive shifter and the pending/output byte registers.
    always_comb begin
        flush_d   = flush_q;
        bit_cnt_d = bit_cnt_q;
        rx_sr_d   = rx_sr_q;
        p_d       = p_q;
        o_d       = o_q;
        if (state_q == ST_WAIT && !flush_done) flush_d = flush_q + FW'(1);
        if (cs_fall_evt || cs_rise_evt) begin
            bit_cnt_d = 3'd0;
        end else if (bit_evt) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            rx_sr_d   = rx_byte;
        end
        if (o_q.valid && output_axis_tready) o_d.valid = 1'b0;
        if (move) o_d = '{valid: 1'b1, data: p_q.data, last: p_last_eff, user: p_q.user};
        if (take_new) begin
            p_d = '{valid: 1'b1, data: rx_byte, last: 1'b0, user: 1'b0};
        end else if (move) begin
            p_d.valid = 1'b0;
        end else if (p_q.valid) begin
            if (drop)        p_d.user = 1'b1;
            if (cs_rise_evt) p_d.last = 1'b1;
        end
    end

    // Receive-path state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_q   <= '0;
            bit_cnt_q <= 3'd0;
            rx_sr_q   <= 8'h00;
            p_q       <= '0;
            o_q       <= '0;
            overrun_q <= 1'b0;
        end else begin
            flush_q   <= flush_d;
            bit_cnt_q <= bit_cnt_d;
            rx_sr_q   <= rx_sr_d;
            p_q       <= p_d;
            o_q       <= o_d;
            overrun_q <= drop;
        end
    end

    assign output_axis_tdata  = o_q.data;
    assign output_axis_tvalid = o_q.valid;
    assign output_axis_tlast  = o_q.last;
    assign output_axis_tuser  = o_q.user;
    assign overrun            = overrun_q;
    assign busy               = ~cs_s | p_q.valid | o_q.valid;

`ifdef SPI_SLAVE_AXIS_MISO_EN
    logic [7:0] tx_sr_q, tx_sr_d;
    logic       tx_load;

    assign tx_load           = cs_fall_evt || byte_done;
    assign input_axis_tready = tx_load && input_axis_tvalid;

    // Load a response byte at frame start and byte boundaries; the fall
    // right after a boundary (count back at 0) must not shift the new byte.
    always_comb begin
        tx_sr_d = tx_sr_q;
        if (cs_rise_evt)
            tx_sr_d = 8'hFF;
        else if (tx_load)
            tx_sr_d = input_axis_tvalid ? input_axis_tdata : IDLE_BYTE;
        else if (sclk_fall && in_frame && bit_cnt_q != 3'd0)
            tx_sr_d = {tx_sr_q[6:0], 1'b1};
    end

    // MISO shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tx_sr_q <= 8'hFF;
        else     tx_sr_q <= tx_sr_d;
    end

    assign miso   = tx_sr_q[7];
    assign miso_t = cs_s;
`else
    logic unused_rsp;
    assign unused_rsp        = ^{input_axis_tdata, input_axis_tvalid, sclk_fall, IDLE_BYTE};
    assign miso              = 1'b1;
    assign miso_t            = 1'b1;
    assign input_axis_tready = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_axis.sv
// Directed bench for spi_slave_axis (either SPI_SLAVE_AXIS_MISO_EN build).
`timescale 1ns/1ps
module tb_spi_slave_axis;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
    logic       miso, miso_t;
    logic [7:0] input_axis_tdata = 8'h00;
    logic       input_axis_tvalid = 1'b0;
    logic       input_axis_tready;
    logic [7:0] output_axis_tdata;
    logic       output_axis_tvalid;
    logic       output_axis_tready = 1'b0;
    logic       output_axis_tlast, output_axis_tuser;
    logic       busy, overrun;

    int vec  = 0;
    int errs = 0;
    int ovr_cnt = 0;
    logic [9:0] rxq[$];   // {tdata, tlast, tuser} of accepted beats

    always #5 clk = ~clk;

    spi_slave_axis dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_t(miso_t),
        .input_axis_tdata(input_axis_tdata), .input_axis_tvalid(input_axis_tvalid),
        .input_axis_tready(input_axis_tready),
        .output_axis_tdata(output_axis_tdata), .output_axis_tvalid(output_axis_tvalid),
        .output_axis_tready(output_axis_tready), .output_axis_tlast(output_axis_tlast),
        .output_axis_tuser(output_axis_tuser), .busy(busy), .overrun(overrun)
    );

    // Record accepted beats and overrun pulses mid-cycle.
    always @(negedge clk) begin
        if (output_axis_tvalid && output_axis_tready)
            rxq.push_back({output_axis_tdata, output_axis_tlast, output_axis_tuser});
        if (overrun) ovr_cnt++;
    end

    // sclk half period is 8 clk cycles; mosi changes on falls, miso read before rises.
    task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            #80;
            rx[7-i] = miso;
            sclk = 1'b1;
            #80;
            sclk = 1'b0;
        end
    endtask

    task automatic frame_start();
        @(negedge clk);
        cs_n = 1'b0;
        #160;
    endtask

    task automatic frame_end();
        #80;
        cs_n = 1'b1;
    endtask

    task automatic set_tready(input logic v);
        @(posedge clk); #1;
        output_axis_tready = v;
    endtask

    task automatic settle();
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [16:0] got;
        repeat (3) @(negedge clk);
        got = {output_axis_tdata, output_axis_tvalid, output_axis_tlast, output_axis_tuser,
               busy, overrun, input_axis_tready, miso, miso_t};
        vec++;
        if (got !== {8'h00, 6'b000000, 2'b11}) begin
            errs++; $display("FAIL reset_outputs: got %h want %h", got, {8'h00, 6'b0, 2'b11});
        end
        @(negedge clk); rst = 1'b0;
        settle();
        vec++;
        if (busy !== 1'b0 || output_axis_tvalid !== 1'b0) begin
            errs++; $display("FAIL reset_release_idle: busy %b tvalid %b want 0 0", busy, output_axis_tvalid);
        end
    endtask

    task automatic test_stream();
        logic [7:0] r;
        logic [9:0] exp [3];
        logic [9:0] got;
        int ov0;
        exp = '{{8'h11, 2'b00}, {8'h22, 2'b00}, {8'h33, 2'b10}};
        ov0 = ovr_cnt;
        set_tready(1'b1);
        frame_start();
        vec++;
        if (busy !== 1'b1) begin errs++; $display("FAIL stream_busy: got %b want 1", busy); end
        spi_xfer(8'h11, 8, r); spi_xfer(8'h22, 8, r); spi_xfer(8'h33, 8, r);
        frame_end();
        settle();
        for (int i = 0; i < 3; i++) begin
            got = (rxq.size() > 0) ? rxq.pop_front() : 10'h3FF;
            vec++;
            if (got !== exp[i]) begin
                errs++; $display("FAIL stream_beat%0d: got %h want %h", i, got, exp[i]);
            end
        end
        vec++;
        if (rxq.size() != 0 || ovr_cnt != ov0) begin
            errs++; $display("FAIL stream_extra: extra beats %0d overruns %0d want 0 0", rxq.size(), ovr_cnt - ov0);
        end
    endtask

    task automatic test_miso();
        logic [7:0] r0, r1, r2;
        int pulses;
        bit done;
        pulses = 0; done = 1'b0;
        r0 = 8'h00; r1 = 8'h00; r2 = 8'h00;
`ifdef SPI_SLAVE_AXIS_MISO_EN
        input_axis_tdata = 8'hA5; input_axis_tvalid = 1'b1;
        fork
            begin
                frame_start();
                spi_xfer(8'h01, 8, r0); spi_xfer(8'h02, 8, r1); spi_xfer(8'h03, 8, r2);
                done = 1'b1;
                frame_end();
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    if (input_axis_tready) begin
                        pulses++;
                        @(posedge clk); #1;
                        if (pulses == 1) input_axis_tdata = 8'h5A;
                        else             input_axis_tvalid = 1'b0;
                    end
                end
            end
        join
        settle();
        vec++; if (r0 !== 8'hA5) begin errs++; $display("FAIL miso_byte0: got %h want a5", r0); end
        vec++; if (r1 !== 8'h5A) begin errs++; $display("FAIL miso_byte1: got %h want 5a", r1); end
        vec++; if (r2 !== 8'hFF) begin errs++; $display("FAIL miso_byte2: got %h want ff", r2); end
        vec++; if (pulses != 2)  begin errs++; $display("FAIL miso_tready_pulses: got %0d want 2", pulses); end
        vec++; if (miso_t !== 1'b1) begin errs++; $display("FAIL miso_t_idle: got %b want 1", miso_t); end
        rxq.delete();
`else
        input_axis_tdata = 8'h00; input_axis_tvalid = 1'b1;
        fork
            begin
                frame_start();
                spi_xfer(8'h3C, 8, r0);
                done = 1'b1;
                frame_end();
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    if (miso !== 1'b1 || miso_t !== 1'b1 || input_axis_tready !== 1'b0) pulses++;
                end
            end
        join
        input_axis_tvalid = 1'b0;
        settle();
        vec++; if (pulses != 0) begin errs++; $display("FAIL miso_disabled: %0d bad cycles want 0", pulses); end
        vec++; if (r0 !== 8'hFF) begin errs++; $display("FAIL miso_disabled_read: got %h want ff", r0); end
        r1 = 8'h00; r2 = 8'h00;
        vec++;
        if (rxq.size() != 1 || rxq[0] !== {8'h3C, 2'b10}) begin
            errs++; $display("FAIL rx_when_miso_off: beats %0d want one 3c/last", rxq.size());
        end
        rxq.delete();
`endif
    endtask

    task automatic test_overrun();
        logic [7:0] r;
        logic [9:0] got;
        int ov0;
        ov0 = ovr_cnt;
        set_tready(1'b0);
        frame_start();
        spi_xfer(8'h01, 8, r); spi_xfer(8'h02, 8, r); spi_xfer(8'h03, 8, r); spi_xfer(8'h04, 8, r);
        frame_end();
        settle();
        vec++;
        if ({output_axis_tvalid, output_axis_tdata, output_axis_tlast} !== {1'b1, 8'h01, 1'b0}) begin
            errs++; $display("FAIL ovr_hold: got v%b d%h l%b want v1 d01 l0",
                             output_axis_tvalid, output_axis_tdata, output_axis_tlast);
        end
        vec++;
        if (ovr_cnt - ov0 != 2) begin errs++; $display("FAIL ovr_pulses: got %0d want 2", ovr_cnt - ov0); end
        vec++;
        if (busy !== 1'b1) begin errs++; $display("FAIL ovr_busy: got %b want 1", busy); end
        set_tready(1'b1);
        settle();
        got = (rxq.size() > 0) ? rxq.pop_front() : 10'h3FF;
        vec++; if (got !== {8'h01, 2'b00}) begin errs++; $display("FAIL ovr_beat0: got %h want 004", got); end
        got = (rxq.size() > 0) ? rxq.pop_front() : 10'h3FF;
        vec++; if (got !== {8'h02, 2'b11}) begin errs++; $display("FAIL ovr_beat1: got %h want 00b", got); end
        vec++;
        if (rxq.size() != 0 || busy !== 1'b0) begin
            errs++; $display("FAIL ovr_drain: extra %0d busy %b want 0 0", rxq.size(), busy);
        end
    endtask

    task automatic test_partial();
        logic [7:0] r;
        logic [9:0] exp [3];
        logic [9:0] got;
        exp = '{{8'h5C, 2'b10}, {8'h96, 2'b00}, {8'h69, 2'b10}};
        frame_start();
        spi_xfer(8'h5C, 8, r); spi_xfer(8'hA0, 5, r);
        frame_end();
        settle();
        frame_start();
        spi_xfer(8'h96, 8, r); spi_xfer(8'h69, 8, r);
        frame_end();
        settle();
        for (int i = 0; i < 3; i++) begin
            got = (rxq.size() > 0) ? rxq.pop_front() : 10'h3FF;
            vec++;
            if (got !== exp[i]) begin errs++; $display("FAIL partial_beat%0d: got %h want %h", i, got, exp[i]); end
        end
        vec++;
        if (rxq.size() != 0) begin errs++; $display("FAIL partial_extra: got %0d want 0", rxq.size()); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] r;
        logic [9:0] got;
        int ov0;
        set_tready(1'b0);
        frame_start();
        spi_xfer(8'h77, 8, r); spi_xfer(8'h88, 8, r); spi_xfer(8'hF0, 3, r);
        vec++;
        if (output_axis_tvalid !== 1'b1) begin errs++; $display("FAIL rstmid_pre: tvalid %b want 1", output_axis_tvalid); end
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        vec++;
        if ({miso_t, miso, output_axis_tvalid, output_axis_tdata, busy} !== {1'b1, 1'b1, 1'b0, 8'h00, 1'b0}) begin
            errs++; $display("FAIL rstmid_async: got t%b m%b v%b d%h b%b want t1 m1 v0 d00 b0",
                             miso_t, miso, output_axis_tvalid, output_axis_tdata, busy);
        end
        @(negedge clk);
        spi_xfer(8'h00, 5, r);
        rst = 1'b0;
        set_tready(1'b1);
        ov0 = ovr_cnt;
        @(negedge clk);
        spi_xfer(8'hE7, 8, r);
        frame_end();
        settle();
        vec++;
        if (rxq.size() != 0 || ovr_cnt != ov0) begin
            errs++; $display("FAIL rstmid_ignore: beats %0d overruns %0d want 0 0", rxq.size(), ovr_cnt - ov0);
        end
        rxq.delete();
        frame_start();
        spi_xfer(8'hC3, 8, r);
        frame_end();
        settle();
        got = (rxq.size() > 0) ? rxq.pop_front() : 10'h3FF;
        vec++; if (got !== {8'hC3, 2'b10}) begin errs++; $display("FAIL rstmid_clean: got %h want 30e", got); end
        vec++; if (rxq.size() != 0) begin errs++; $display("FAIL rstmid_extra: got %0d want 0", rxq.size()); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] r;
        logic [9:0] exp [4];
        logic [9:0] got;
        int ov0;
        exp = '{{8'hAA, 2'b00}, {8'hBB, 2'b10}, {8'hCC, 2'b00}, {8'hDD, 2'b10}};
        ov0 = ovr_cnt;
        frame_start();
        spi_xfer(8'hAA, 8, r); spi_xfer(8'hBB, 8, r);
        frame_end();
        repeat (2) @(negedge clk);
        cs_n = 1'b0;
        #160;
        spi_xfer(8'hCC, 8, r); spi_xfer(8'hDD, 8, r);
        frame_end();
        settle();
        for (int i = 0; i < 4; i++) begin
            got = (rxq.size() > 0) ? rxq.pop_front() : 10'h3FF;
            vec++;
            if (got !== exp[i]) begin errs++; $display("FAIL b2b_beat%0d: got %h want %h", i, got, exp[i]); end
        end
        vec++;
        if (ovr_cnt != ov0 || rxq.size() != 0) begin
            errs++; $display("FAIL b2b_clean: overruns %0d extra %0d want 0 0", ovr_cnt - ov0, rxq.size());
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_miso();
        test_overrun();
        test_partial();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
